// File: rtl/free_list_if.sv
// rtl/free_list_if.sv - free-list handshake bundle and shared width/branch-state macros
`ifndef LRF_IDX_W
`define LRF_IDX_W 5
`endif
`ifndef PRF_IDX_W
`define PRF_IDX_W 6
`endif
`ifndef BR_STATE_W
`define BR_STATE_W 2
`endif
`ifndef BR_NONE
`define BR_NONE 2'd0
`endif
`ifndef BR_PR_CORRECT
`define BR_PR_CORRECT 2'd1
`endif
`ifndef BR_PR_WRONG
`define BR_PR_WRONG 2'd2
`endif

interface free_list_if;
  logic                   pop_i;
  logic                   push_i;
  logic [`PRF_IDX_W-1:0]  push_prf_i;
  logic [`BR_STATE_W-1:0] br_state_i;
  logic [`LRF_IDX_W-1:0]  rc_fl_head_i;
  logic [`PRF_IDX_W-1:0]  free_prf_o;
  logic                   empty_o;
  logic [`LRF_IDX_W-1:0]  bak_fl_head_o;
  logic [`LRF_IDX_W:0]    count_o;

  modport master (
    output pop_i, push_i, push_prf_i, br_state_i, rc_fl_head_i,
    input  free_prf_o, empty_o, bak_fl_head_o, count_o
  );

  modport slave (
    input  pop_i, push_i, push_prf_i, br_state_i, rc_fl_head_i,
    output free_prf_o, empty_o, bak_fl_head_o, count_o
  );
endinterface

// File: rtl/free_list.sv
// rtl/free_list.sv - circular PRF-tag free list with branch-mispredict head recovery
// Optional FL_BYPASS_EN: an empty list serves a same-cycle pop straight from the push tag.
module free_list #(
  parameter int FL_DEPTH = 32,
  parameter int PRF_BASE = 32
) (
  input logic       clk,
  input logic       rst,
  free_list_if.slave fl
);

  localparam int LW = `LRF_IDX_W;
  localparam int PW = `PRF_IDX_W;
  localparam int CW = `LRF_IDX_W + 1;
  localparam logic [CW-1:0] FULL     = CW'(FL_DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [LW-1:0] PTR_ONE  = LW'(1);

  logic [PW-1:0] entry [FL_DEPTH];
  logic [LW-1:0] head;
  logic [LW-1:0] tail;
  logic [CW-1:0] count;

  logic          mispredict;
  logic          is_empty;
  logic          bypass;
  logic          push_ok;
  logic          pop_ok;
  logic [LW-1:0] rc_dist;
  logic [CW-1:0] rc_count;
  logic [CW-1:0] count_d;

  assign mispredict = (fl.br_state_i == `BR_PR_WRONG);
  assign is_empty   = (count == '0);

`ifdef FL_BYPASS_EN
  assign bypass = is_empty & fl.push_i & fl.pop_i & ~mispredict;
`else
  assign bypass = 1'b0;
`endif

  // A push into a full list is dropped so the count can never exceed the depth.
  assign push_ok = fl.push_i & (count != FULL);
  assign pop_ok  = fl.pop_i & ~mispredict & (~is_empty | bypass);

  // Recovered occupancy is the distance from the restored head to the pre-push tail;
  // a zero distance with no push means every slot was outstanding, i.e. a full list.
  assign rc_dist  = tail - fl.rc_fl_head_i;
  assign rc_count = (rc_dist == '0 && !push_ok) ? FULL
                  : ({1'b0, rc_dist} + (push_ok ? CNT_ONE : '0));

  always_comb begin
    count_d = count;
    if (mispredict) begin
      count_d = rc_count;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count_d = count + CNT_ONE;
        2'b01:   count_d = count - CNT_ONE;
        default: count_d = count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        entry[i] <= PW'(PRF_BASE + i);
      end
      head  <= '0;
      tail  <= '0;
      count <= FULL;
    end else begin
      if (push_ok) begin
        entry[tail] <= fl.push_prf_i;
        tail        <= tail + PTR_ONE;
      end
      if (mispredict) begin
        head <= fl.rc_fl_head_i;
      end else if (pop_ok) begin
        head <= head + PTR_ONE;
      end
      count <= count_d;
    end
  end

  assign fl.free_prf_o    = bypass ? fl.push_prf_i : entry[head];
  assign fl.empty_o       = is_empty & ~bypass;
  assign fl.bak_fl_head_o = head;
  assign fl.count_o       = count;

  no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
    !(fl.push_i && count == FULL));

endmodule

// File: tb/tb_free_list.sv
// tb/tb_free_list.sv - directed self-checking bench for free_list
module tb_free_list;

  logic clk;
  logic rst;
  int   passed;
  int   total;
  logic [`LRF_IDX_W-1:0] cap_head;

  free_list_if bus ();

  free_list #(.FL_DEPTH(32), .PRF_BASE(32)) dut (
    .clk (clk),
    .rst (rst),
    .fl  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic idle();
    bus.pop_i        = 1'b0;
    bus.push_i       = 1'b0;
    bus.push_prf_i   = '0;
    bus.br_state_i   = `BR_NONE;
    bus.rc_fl_head_i = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    step();
    rst = 1'b1;
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_free"},  32'(bus.free_prf_o),    32);
    check({tag, "_count"}, 32'(bus.count_o),       32);
    check({tag, "_head"},  32'(bus.bak_fl_head_o), 0);
    check({tag, "_empty"}, 32'(bus.empty_o),       0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    passed = 0;
    total  = 0;
    idle();
    rst = 1'b0;
    step();
    step();
    check_reset_outputs("in_reset");
    rst = 1'b1;
    #1;
    check_reset_outputs("post_reset");

    // Drain all 32 reset tags in order, then one more pop on the empty list.
    bus.pop_i = 1'b1;
    for (int i = 0; i < 32; i++) begin
      check("drain_tag", 32'(bus.free_prf_o), 32'(32 + i));
      step();
    end
    check("drained_empty", 32'(bus.empty_o), 1);
    check("drained_count", 32'(bus.count_o), 0);
    check("drained_head",  32'(bus.bak_fl_head_o), 0);
    step();
    check("underflow_count", 32'(bus.count_o), 0);
    check("underflow_empty", 32'(bus.empty_o), 1);
    check("underflow_head",  32'(bus.bak_fl_head_o), 0);

    // Push and pop together on an empty list.
    bus.push_i     = 1'b1;
    bus.push_prf_i = 6'd20;
    #1;
`ifdef FL_BYPASS_EN
    check("byp_free",  32'(bus.free_prf_o), 20);
    check("byp_empty", 32'(bus.empty_o), 0);
    step();
    check("byp_count", 32'(bus.count_o), 0);
    check("byp_head",  32'(bus.bak_fl_head_o), 1);
    idle();
`else
    check("nobyp_empty", 32'(bus.empty_o), 1);
    step();
    check("nobyp_count", 32'(bus.count_o), 1);
    check("nobyp_free",  32'(bus.free_prf_o), 20);
    check("nobyp_head",  32'(bus.bak_fl_head_o), 0);
    idle();
    bus.pop_i = 1'b1;
    step();
    idle();
    check("nobyp_drain", 32'(bus.count_o), 0);
`endif

    // Walk both pointers to slot 30 so the next pushes wrap the tail.
    for (int i = 0; i < 29; i++) begin
      bus.push_i     = 1'b1;
      bus.push_prf_i = 6'(i + 1);
      step();
    end
    idle();
    check("fill29_count", 32'(bus.count_o), 29);
    bus.pop_i = 1'b1;
    repeat (29) step();
    idle();
    check("walk_empty", 32'(bus.empty_o), 1);
    check("walk_head",  32'(bus.bak_fl_head_o), 30);

    for (int i = 0; i < 5; i++) begin
      bus.push_i     = 1'b1;
      bus.push_prf_i = 6'(7 + 2 * i);
      step();
    end
    idle();
    check("wrap_count", 32'(bus.count_o), 5);
    check("wrap_free",  32'(bus.free_prf_o), 7);

    // Push and pop together with entries present: count holds, both pointers move.
    bus.push_i     = 1'b1;
    bus.push_prf_i = 6'd17;
    bus.pop_i      = 1'b1;
    #1;
    check("pp_free_before", 32'(bus.free_prf_o), 7);
    step();
    idle();
    check("pp_count", 32'(bus.count_o), 5);
    check("pp_head",  32'(bus.bak_fl_head_o), 31);

    bus.pop_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("wrap_tag",  32'(bus.free_prf_o), 32'(9 + 2 * k));
      check("wrap_head", 32'(bus.bak_fl_head_o), 32'((31 + k) % 32));
      step();
    end
    idle();
    check("wrap_end_empty", 32'(bus.empty_o), 1);
    check("wrap_end_head",  32'(bus.bak_fl_head_o), 4);

    // Recovery to a head equal to the tail restores a full list.
    do_reset();
    bus.pop_i = 1'b1;
    repeat (3) step();
    idle();
    check("pre_full_rc_count", 32'(bus.count_o), 29);
    bus.br_state_i   = `BR_PR_WRONG;
    bus.rc_fl_head_i = 5'd0;
    bus.pop_i        = 1'b1;
    step();
    idle();
    check("full_rc_count", 32'(bus.count_o), 32);
    check("full_rc_head",  32'(bus.bak_fl_head_o), 0);
    check("full_rc_free",  32'(bus.free_prf_o), 32);

    // Checkpoint at head 10, speculate 6 more, then mispredict with a retiring push.
    do_reset();
    bus.pop_i = 1'b1;
    repeat (10) step();
    cap_head = bus.bak_fl_head_o;
    check("ckpt_head", 32'(cap_head), 10);
    repeat (6) step();
    check("spec_count", 32'(bus.count_o), 16);
    bus.br_state_i   = `BR_PR_WRONG;
    bus.rc_fl_head_i = cap_head;
    bus.push_i       = 1'b1;
    bus.push_prf_i   = 6'd3;
    step();
    idle();
    check("rc_head",  32'(bus.bak_fl_head_o), 10);
    check("rc_free",  32'(bus.free_prf_o), 42);
    check("rc_count", 32'(bus.count_o), 23);

    // A correctly predicted branch leaves the pop path untouched.
    bus.br_state_i = `BR_PR_CORRECT;
    bus.pop_i      = 1'b1;
    step();
    idle();
    check("correct_head",  32'(bus.bak_fl_head_o), 11);
    check("correct_count", 32'(bus.count_o), 22);
    check("correct_free",  32'(bus.free_prf_o), 43);

    // Reset asserted in the middle of a push+pop cycle.
    bus.push_i     = 1'b1;
    bus.push_prf_i = 6'd5;
    bus.pop_i      = 1'b1;
    step();
    check("mid_head", 32'(bus.bak_fl_head_o), 12);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    step();
    check_reset_outputs("reset_overrides");
    idle();
    rst = 1'b1;
    #1;
    check_reset_outputs("after_release");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
